// File: rtl/accum_sequencer.sv
// rtl/accum_sequencer.sv - job sequencer for the FP accumulator of one convolution output
// Clears the accumulator, streams len terms into it, then captures and presents the sum.
module accum_sequencer #(
    parameter int BITWIDTH = 12,
    parameter int BW       = BITWIDTH + 2 - 1,
    parameter int MAX_LEN  = 256,
    parameter int CNT_W    = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic [BW:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             acc_clear,
    output logic             acc_enable,
    output logic [BW:0]      acc_in,
    input  logic [BW:0]      acc_sum,
    output logic [BW:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             err_len
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_len_q;
    logic             r_err_len;

    logic w_len_ok;
    logic w_abort;
    logic w_handshake;
    logic w_start_window;
    logic w_accept;
    logic w_last;

    assign w_len_ok       = (len != '0) && (len <= CNT_W'(MAX_LEN));
    assign w_abort        = abort && (r_state != S_IDLE);
    assign w_handshake    = (r_state == S_HOLD) && out_ready && !w_abort;
    // A new job may be taken from IDLE or on the very cycle the result is consumed
    assign w_start_window = start && ((r_state == S_IDLE) || w_handshake);
    assign w_accept       = (r_state == S_RUN) && in_valid && !abort;
    assign w_last         = w_accept && (r_count == (r_len_q - CNT_W'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start && w_len_ok) w_next = S_CLR;
                S_CLR:   w_next = S_RUN;
                S_RUN:   if (w_last) w_next = S_DRAIN;
                S_DRAIN: w_next = S_HOLD;
                S_HOLD: begin
                    if (w_handshake) begin
                        w_next = (start && w_len_ok) ? S_CLR : S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = (r_state == S_RUN) && !abort;
        acc_clear  = (r_state == S_CLR) || w_abort;
        acc_enable = in_valid && in_ready;
        acc_in     = in_data;
        out_valid  = (r_state == S_HOLD);
        busy       = (r_state != S_IDLE);
        err_len    = r_err_len;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= '0;
            r_len_q   <= '0;
            r_err_len <= 1'b0;
            out_data  <= '0;
        end else begin
            r_err_len <= w_start_window && !w_len_ok;
            if (w_abort) begin
                r_count <= '0;
            end else if (w_start_window && w_len_ok) begin
                r_len_q <= len;
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= r_count + CNT_W'(1);
            end
            // The accumulator register settles one cycle after the last accepted term
            if ((r_state == S_DRAIN) && !w_abort) begin
                out_data <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_accum_sequencer.sv
// tb/tb_accum_sequencer.sv - directed bench for accum_sequencer
// A behavioural accumulator is attached so result capture can be checked end to end.
module tb_accum_sequencer;

    localparam int BW      = 13;
    localparam int CNT_W   = 9;
    localparam int MAX_LEN = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             abort;
    logic [BW:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic             acc_clear;
    logic             acc_enable;
    logic [BW:0]      acc_in;
    logic [BW:0]      acc_sum;
    logic [BW:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             err_len;

    logic [BW:0] acc_reg = '0;

    int n_checks = 0;
    int n_errors = 0;
    int clr_cnt  = 0;
    int en_cnt   = 0;
    int err_cnt  = 0;
    int ov_cnt   = 0;
    int hs_cnt   = 0;
    int both_cnt = 0;

    logic [BW:0] tog_terms [3] = '{14'h0011, 14'h0102, 14'h1003};
    logic        tog_valid [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    accum_sequencer #(.BITWIDTH(12), .MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .abort      (abort),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .acc_clear  (acc_clear),
        .acc_enable (acc_enable),
        .acc_in     (acc_in),
        .acc_sum    (acc_sum),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .err_len    (err_len)
    );

    always @(posedge clk) begin
        if (acc_clear) acc_reg <= '0;
        else if (acc_enable) acc_reg <= acc_reg + acc_in;
    end
    assign acc_sum = acc_reg;

    always @(negedge clk) begin
        if (acc_clear) clr_cnt++;
        if (acc_enable) en_cnt++;
        if (err_len) err_cnt++;
        if (out_valid) ov_cnt++;
        if (out_valid && out_ready) hs_cnt++;
        if (acc_clear && acc_enable) both_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic test_reset();
        settle();
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
        n_checks++; if (acc_clear !== 1'b0 || acc_enable !== 1'b0) begin n_errors++; $display("FAIL reset_acc_ctl: clr=%0b en=%0b want 0 0", acc_clear, acc_enable); end
        n_checks++; if (out_valid !== 1'b0 || err_len !== 1'b0) begin n_errors++; $display("FAIL reset_flags: ov=%0b err=%0b want 0 0", out_valid, err_len); end
        n_checks++; if (out_data !== 14'h0000) begin n_errors++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int c0, e0, h0;
        c0 = clr_cnt; e0 = en_cnt; h0 = hs_cnt;
        start = 1'b1; len = 9'd4;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 14'h0C00;
        settle();
        n_checks++; if (acc_clear !== 1'b1 || in_ready !== 1'b0) begin n_errors++; $display("FAIL basic_clr: clr=%0b rdy=%0b want 1 0", acc_clear, in_ready); end
        tick();
        for (int i = 0; i < 4; i++) begin
            settle();
            n_checks++; if (acc_enable !== 1'b1) begin n_errors++; $display("FAIL basic_en%0d: got %0b want 1", i, acc_enable); end
            tick();
        end
        settle();
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drain: rdy=%0b ov=%0b want 0 0", in_ready, out_valid); end
        tick();
        in_valid = 1'b0;
        settle();
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_ov_latency: got %0b want 1", out_valid); end
        n_checks++; if (out_data !== 14'h3000) begin n_errors++; $display("FAIL basic_sum: got %h want 3000", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        settle();
        n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_idle: busy=%0b ov=%0b want 0 0", busy, out_valid); end
        n_checks++; if (clr_cnt - c0 != 1) begin n_errors++; $display("FAIL basic_clr_cycles: got %0d want 1", clr_cnt - c0); end
        n_checks++; if (en_cnt - e0 != 4) begin n_errors++; $display("FAIL basic_en_cycles: got %0d want 4", en_cnt - e0); end
        n_checks++; if (hs_cnt - h0 != 1) begin n_errors++; $display("FAIL basic_handshakes: got %0d want 1", hs_cnt - h0); end
    endtask

    task automatic test_toggle();
        int e0, h0, k;
        e0 = en_cnt; h0 = hs_cnt; k = 0;
        start = 1'b1; len = 9'd3;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = tog_valid[i];
            in_data  = tog_valid[i] ? tog_terms[k] : 14'h3FFF;
            settle();
            n_checks++; if (acc_enable !== tog_valid[i]) begin n_errors++; $display("FAIL toggle_en%0d: got %0b want %0b", i, acc_enable, tog_valid[i]); end
            if (tog_valid[i]) k++;
            tick();
        end
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            n_checks++; if (out_valid !== 1'b1 || out_data !== 14'h1116) begin n_errors++; $display("FAIL toggle_hold%0d: ov=%0b data=%h want 1 1116", i, out_valid, out_data); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        settle();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL toggle_release: got %0b want 0", out_valid); end
        n_checks++; if (en_cnt - e0 != 3) begin n_errors++; $display("FAIL toggle_en_cycles: got %0d want 3", en_cnt - e0); end
        n_checks++; if (hs_cnt - h0 != 1) begin n_errors++; $display("FAIL toggle_handshakes: got %0d want 1", hs_cnt - h0); end
    endtask

    task automatic test_err_len();
        int c0, r0;
        c0 = clr_cnt; r0 = err_cnt;
        start = 1'b1; len = 9'd0;
        tick();
        start = 1'b0;
        settle();
        n_checks++; if (err_len !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL err_zero: err=%0b busy=%0b want 1 0", err_len, busy); end
        tick();
        settle();
        n_checks++; if (err_len !== 1'b0) begin n_errors++; $display("FAIL err_zero_pulse: got %0b want 0", err_len); end
        start = 1'b1; len = 9'd257;
        tick();
        start = 1'b0;
        settle();
        n_checks++; if (err_len !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL err_big: err=%0b busy=%0b want 1 0", err_len, busy); end
        tick();
        settle();
        n_checks++; if (err_len !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL err_big_pulse: err=%0b busy=%0b want 0 0", err_len, busy); end
        n_checks++; if (clr_cnt - c0 != 0) begin n_errors++; $display("FAIL err_no_clear: got %0d want 0", clr_cnt - c0); end
        n_checks++; if (err_cnt - r0 != 2) begin n_errors++; $display("FAIL err_pulses: got %0d want 2", err_cnt - r0); end
        tick();
    endtask

    task automatic test_abort();
        int o0;
        o0 = ov_cnt;
        abort = 1'b1;
        settle();
        n_checks++; if (acc_clear !== 1'b0) begin n_errors++; $display("FAIL abort_idle_clr: got %0b want 0", acc_clear); end
        tick();
        abort = 1'b0;
        start = 1'b1; len = 9'd8;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 14'h0005;
        tick();
        tick();
        abort = 1'b1;
        settle();
        n_checks++; if (acc_clear !== 1'b1 || acc_enable !== 1'b0 || in_ready !== 1'b0) begin n_errors++; $display("FAIL abort_cycle: clr=%0b en=%0b rdy=%0b want 1 0 0", acc_clear, acc_enable, in_ready); end
        tick();
        abort = 1'b0; in_valid = 1'b0;
        settle();
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_idle: busy=%0b want 0", busy); end
        n_checks++; if (out_data !== 14'h1116) begin n_errors++; $display("FAIL abort_out_data: got %h want 1116", out_data); end
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (ov_cnt - o0 != 0) begin n_errors++; $display("FAIL abort_no_ov: got %0d want 0", ov_cnt - o0); end
    endtask

    task automatic test_back_to_back();
        int h0;
        h0 = hs_cnt;
        start = 1'b1; len = 9'd2;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 14'h0001;
        tick();
        in_data = 14'h0002;
        tick();
        in_valid = 1'b0;
        tick();
        settle();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 14'h0003) begin n_errors++; $display("FAIL b2b_first: ov=%0b data=%h want 1 0003", out_valid, out_data); end
        out_ready = 1'b1; start = 1'b1; len = 9'd2;
        tick();
        out_ready = 1'b0; start = 1'b0;
        settle();
        n_checks++; if (acc_clear !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_clr: clr=%0b busy=%0b ov=%0b want 1 1 0", acc_clear, busy, out_valid); end
        tick();
        in_valid = 1'b1; in_data = 14'h0100;
        tick();
        in_data = 14'h0200;
        tick();
        in_valid = 1'b0;
        tick();
        settle();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 14'h0300) begin n_errors++; $display("FAIL b2b_second: ov=%0b data=%h want 1 0300", out_valid, out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        settle();
        n_checks++; if (hs_cnt - h0 != 2 || busy !== 1'b0) begin n_errors++; $display("FAIL b2b_handshakes: hs=%0d busy=%0b want 2 0", hs_cnt - h0, busy); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; len = 9'd8;
        tick();
        start = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 14'h0007;
        tick();
        tick();
        tick();
        rst = 1'b0;
        settle();
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_ctl: busy=%0b rdy=%0b ov=%0b want 0 0 0", busy, in_ready, out_valid); end
        n_checks++; if (out_data !== 14'h0000) begin n_errors++; $display("FAIL rstmid_out_data: got %h want 0000", out_data); end
        tick();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        settle();
        n_checks++; if (busy !== 1'b0 || acc_enable !== 1'b0) begin n_errors++; $display("FAIL rstmid_after: busy=%0b en=%0b want 0 0", busy, acc_enable); end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_toggle();
        test_err_len();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        n_checks++; if (both_cnt != 0) begin n_errors++; $display("FAIL clr_en_overlap: got %0d want 0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/accum_sequencer.md
Name: accum_sequencer

Overview:
Controller that sequences the 14-bit floating-point accumulator (FP adder plus sum register) for one convolution output.
- Per job: clears the accumulator, streams exactly `len` product terms into it under valid/ready flow control, waits one cycle for the final add, captures the sum and presents it on a valid/ready result port.
- Sits between the multiplier array output and the activation/adapter stage.

Parameters:
- BITWIDTH, 12, FP significand/exponent payload width; data words are BITWIDTH+2 bits (2 exception bits).
- BW, BITWIDTH+2-1, MSB index of every data word (13 by default).
- MAX_LEN, 256, largest legal number of terms per job.
- CNT_W, $clog2(MAX_LEN+1), width of length/count fields.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  job request, sampled in IDLE (or HOLD with result handshake)
- len  in  CNT_W  terms in the job, sampled with start
- abort  in  1  cancel the current job
- in_data  in  BW+1  product term
- in_valid  in  1  in_data valid
- in_ready  out  1  sequencer accepts in_data
- acc_clear  out  1  to accumulator clear
- acc_enable  out  1  to accumulator enable
- acc_in  out  BW+1  to accumulator addend (acc)
- acc_sum  in  BW+1  accumulator registered sum
- out_data  out  BW+1  captured result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- busy  out  1  state != IDLE
- err_len  out  1  one-cycle pulse: illegal len rejected

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; count=0; len_q=0; out_data=0.
  - in_ready, acc_clear, acc_enable, out_valid, busy and err_len are all 0.
- States: IDLE, CLR, RUN, DRAIN, HOLD.
- IDLE:
  - start with 1<=len<=MAX_LEN: latch len_q=len, count=0, go to CLR.
  - start with len==0 or len>MAX_LEN: err_len=1 for the next cycle, stay in IDLE.
- CLR (1 cycle): acc_clear=1, in_ready=0, then go to RUN.
- RUN:
  - in_ready=1.
  - acc_enable = in_valid & in_ready (combinational). acc_in = in_data (combinational, all states).
  - On each accept, count increments.
  - An accept with count==len_q-1 goes to DRAIN; no further terms are accepted that cycle onward.
  - in_valid low: hold, no enable, no timeout.
- DRAIN (1 cycle):
  - in_ready=0.
  - acc_sum now holds the final sum; register out_data<=acc_sum, then go to HOLD.
- HOLD:
  - out_valid=1 and out_data stable until out_ready.
  - On handshake, go to IDLE.
  - If start is also high on the handshake cycle with legal len, go directly to CLR (back-to-back jobs, no idle bubble). Illegal len in that case behaves as in IDLE: pulse err_len, go to IDLE.
  - start in any other state/cycle is ignored.
- Latency:
  - start to first possible accept: 2 cycles (CLR then RUN).
  - Last accept to out_valid: 2 cycles.
  - Minimum job length: len+4 cycles including the result handshake.
- abort:
  - Highest priority, any non-IDLE state. In the abort cycle: acc_clear=1, acc_enable=0, in_ready=0.
  - Next state is IDLE, out_valid drops next cycle, out_data retains its old value, count=0.
  - abort in IDLE: no effect, no acc_clear.
- Priority within a cycle: abort > result handshake/start > term accept.
- acc_clear and acc_enable are never high in the same cycle.
- No arithmetic is done here. Word widths pass through unchanged; count never exceeds len_q.
- Reset mid-job returns to IDLE immediately. The accumulator's own reset is independent.

Test Plan:
- Reset while in RUN with count=3 -> next edge: state IDLE, busy=0, in_ready=0, out_valid=0, out_data=0.
- start, len=4; terms 0x0C00, 0x0C00, 0x0C00, 0x0C00 with in_valid constant (behavioural FP adder attached) -> acc_clear exactly 1 cycle; acc_enable exactly 4 cycles; out_valid 2 cycles after the 4th accept; out_data == model sum.
- len=3 with in_valid toggling 1,0,1,0,1 -> exactly 3 enables, none in invalid cycles; out_data matches model; out_ready held 0 for 5 cycles -> out_valid and out_data stable throughout.
- len=0, then len=MAX_LEN+1 -> err_len one-cycle pulse each; busy stays 0; no acc_clear.
- abort in RUN after 2 of len=8 terms -> acc_clear=1 and acc_enable=0 that cycle; IDLE next cycle; out_valid never asserted.
- HOLD, out_ready=1 and start=1 with len=2 in the same cycle -> CLR next cycle; second result appears correctly; first result consumed exactly once.
